// File: rtl/rv32i_lsu_ctrl.sv
// Load/store sequencer between EX and the synchronous RAM data port.
// Splits boundary-crossing accesses into two aligned words and extends load data.
module rv32i_lsu_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter bit SPLIT_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_width,
    input  logic                  req_sign,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  sign_q, sign_d;
    logic                  err_q, err_d;
    logic                  split_q, split_d;
    logic                  fresh_q, fresh_d;
    logic [1:0]            width_q, width_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            mask_q, mask_d;
    logic [63:0]           data_q, data_d;
    logic [31:0]           lo_q, lo_d;
    logic [31:0]           hi_q, hi_d;

    logic [3:0]  base;
    logic [7:0]  mask_new;
    logic [63:0] data_new;
    logic [31:0] lo_word, hi_word, sh_word, ext_word;

    always_comb begin
        base = 4'b1111;
        case (req_width)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        mask_new = {4'b0000, base} << req_addr[1:0];
        data_new = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sign_d    = sign_q;
        err_d     = err_q;
        split_d   = split_q;
        fresh_d   = fresh_q;
        width_d   = width_q;
        off_d     = off_q;
        waddr_d   = waddr_q;
        mask_d    = mask_q;
        data_d    = data_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    sign_d  = req_sign;
                    width_d = req_width;
                    off_d   = req_addr[1:0];
                    waddr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mask_d  = mask_new;
                    data_d  = data_new;
                    split_d = (mask_new[7:4] != 4'b0000);
                    fresh_d = 1'b0;
                    err_d   = (req_width == 2'b11) ||
                              ((mask_new[7:4] != 4'b0000) && !SPLIT_EN);
                    state_d = err_d ? DONE : FIRST;
                end
            end
            // Write strobes are gated by reset_n so a write in flight is dropped on the reset edge.
            FIRST: begin
                mem_addr  = waddr_q;
                mem_be    = mask_q[3:0] & {4{reset_n}};
                mem_wdata = data_q[31:0];
                mem_we    = we_q & reset_n;
                fresh_d   = 1'b1;
                state_d   = split_q ? SECOND : DONE;
            end
            SECOND: begin
                mem_addr  = waddr_q + ADDR_WIDTH'(4);
                mem_be    = mask_q[7:4] & {4{reset_n}};
                mem_wdata = data_q[63:32];
                mem_we    = we_q & reset_n;
                lo_d      = mem_rdata;
                fresh_d   = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (fresh_q) begin
                    fresh_d = 1'b0;
                    if (split_q) hi_d = mem_rdata;
                    else         lo_d = mem_rdata;
                end
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In the first DONE cycle the RAM output is used directly, afterwards the captured copy.
    always_comb begin
        lo_word  = (fresh_q && !split_q) ? mem_rdata : lo_q;
        hi_word  = (fresh_q && split_q)  ? mem_rdata : hi_q;
        sh_word  = 32'({hi_word, lo_word} >> {off_q, 3'b000});
        ext_word = sh_word;
        case (width_q)
            2'b00:   ext_word = sign_q ? {{24{sh_word[7]}}, sh_word[7:0]}
                                       : {24'b0, sh_word[7:0]};
            2'b01:   ext_word = sign_q ? {{16{sh_word[15]}}, sh_word[15:0]}
                                       : {16'b0, sh_word[15:0]};
            default: ext_word = sh_word;
        endcase
        rsp_rdata = (state_q == DONE && !we_q && !err_q) ? ext_word : 32'b0;
        rsp_err   = err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            fresh_q <= 1'b0;
            width_q <= 2'b00;
            off_q   <= 2'b00;
            waddr_q <= '0;
            mask_q  <= 8'b0;
            data_q  <= 64'b0;
            lo_q    <= 32'b0;
            hi_q    <= 32'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            split_q <= split_d;
            fresh_q <= fresh_d;
            width_q <= width_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: doc/rv32i_lsu_ctrl.md
Name: rv32i_lsu_ctrl

Overview:
- Load/store sequencer between the EX stage and the data port of the synchronous dual-port RAM.
- Accepts one request at a time over a valid/ready handshake and generates the byte enables and lane-shifted write data.
- Splits word- or half-accesses that cross a word boundary into two aligned RAM accesses.
- Waits out the 1-cycle RAM read latency, then returns sign- or zero-extended load data over a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 32, width of the byte address.
- SPLIT_EN, 1: 1 = split misaligned accesses into two words; 0 = misaligned access gets an error response.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_width  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal width, or misaligned access with SPLIT_EN=0
- mem_addr  out  ADDR_WIDTH  word-aligned byte address to RAM d_addr (bits[1:0]=00)
- mem_we  out  1  RAM write enable
- mem_be  out  4  RAM byte-lane enables
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  RAM read data, valid 1 cycle after mem_addr

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is synchronous and active-low: reset_n sampled on the rising edge of clk.
  - Reset values: state IDLE, rsp_valid 0, rsp_err 0, rsp_rdata 0, all latched request registers 0.
  - Because state is IDLE after reset, mem_we, mem_be, mem_wdata and mem_addr are all 0.
- States: IDLE, FIRST, SECOND, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch the request: off = addr[1:0].
  - Form the 8-bit mask m = base << off, where base = 0001 (byte), 0011 (half), 1111 (word).
  - Form the 64-bit data d = {32'b0, wdata} << 8*off.
  - If width==11, or m[7:4]!=0 with SPLIT_EN=0: go to DONE with rsp_err=1 and no RAM access.
  - Otherwise go to FIRST.
- FIRST:
  - mem_addr = {addr[31:2], 2'b00}, mem_be = m[3:0], mem_wdata = d[31:0], mem_we = req_we.
  - If m[7:4]!=0, go to SECOND; else go to DONE.
- SECOND:
  - mem_addr = first address + 4 (wraps modulo 2^ADDR_WIDTH), mem_be = m[7:4], mem_wdata = d[63:32], mem_we = req_we.
  - Capture mem_rdata as lo word.
  - Go to DONE.
- DONE:
  - rsp_valid = 1.
  - On entry, capture mem_rdata: as hi word if the access was split, else as lo word.
  - rsp_rdata is computed from {hi, lo} >> 8*off, truncated to the access size and extended per req_sign. Loads only; stores return 0.
  - Hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
  - rsp_err clears on leaving DONE.
- Latency, measured from the accept edge:
  - Aligned access: rsp_valid 2 cycles later.
  - Split access: 3 cycles.
  - Error: 1 cycle.
  - Throughput: at most one request in flight; the next accept happens in the cycle after the response handshake.
- Outside FIRST and SECOND: mem_we=0, mem_be=0000, mem_addr=0 and mem_wdata=0. Stores never touch RAM lanes outside m.
- Split order is fixed: the lower word is written first, and each write is issued exactly once.
- Reset mid-operation: the controller returns to IDLE on that edge and any pending response is dropped. An unissued second word of a split store is never written, and a first word already written is not rolled back.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside DONE.

Test Plan:
1. Aligned word store then load:
   - SW 0x12345678 @0x0C → FIRST: mem_addr 0x0C, be 1111, wdata 0x12345678, we 1; rsp_valid 2 cycles after accept, err 0.
   - LW @0x0C → rsp_rdata 0x12345678.
2. Byte store and loads:
   - SB 0x1191 @0x51 → mem_addr 0x50, be 0010, wdata 0x00119100.
   - LB signed @0x51 → 0xFFFFFF91; LBU @0x51 → 0x00000091.
3. Split word store and loads:
   - SW 0xAABBCCDD @0x53 → FIRST: addr 0x50, be 1000, wdata 0xDD000000; SECOND: addr 0x54, be 0111, wdata 0x00AABBCC; rsp 3 cycles after accept.
   - LW @0x53 → 0xAABBCCDD; LH signed @0x53 → 0xFFFFCCDD.
4. Backpressure:
   - Hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid and rsp_rdata stable, req_ready 0, mem_we 0 throughout.
   - Release rsp_ready → IDLE the next cycle.
5. Error responses:
   - req_width=11 → rsp_err 1, rsp_rdata 0, 1 cycle after accept, mem_we never 1.
   - With SPLIT_EN=0, LW @0x52 → same error response.
6. Reset mid-split:
   - reset_n=0 in SECOND of SW 0xAABBCCDD @0x53 → next cycle IDLE, rsp_valid 0, mem_we 0.
   - Word 0x54 lanes 0–2 unchanged and word 0x50 lane 3 = 0xDD; req_ready 1 once reset_n=1.
